clk_rst_sequencer: RTL
======================

Name: clk_rst_sequencer

Overview:
- Power-up and recovery sequencer for the Ethernet reference-clock MMCM and its downstream logic.
- Runs on the free-running buffered 100 MHz board clock:
  - pulses the MMCM reset;
  - qualifies LOCKED (synchronised, must stay stable);
  - opens the BUFGCE gating the 25 MHz PHY reference clock;
  - sequences the external PHY reset, then releases system reset.
- Handles loss of lock, lock timeouts with bounded retries, and a manual restart.
- Sits in top between the clock buffers/MMCM and all consumers of the generated clock.

Parameters:
- RST_CYCLES, 16: cycles mmcm_rst is held high per attempt (min 1).
- LOCK_TIMEOUT, 100000: cycles to wait for lock after mmcm_rst falls (1 ms at 100 MHz).
- STABLE_CYCLES, 1024: consecutive synchronised-locked cycles required before opening clk_ce.
- PHY_RST_CYCLES, 1000000: cycles phy_rst_n is held low with the reference clock running (10 ms).
- PHY_WAIT_CYCLES, 5000: cycles after phy_rst_n rises before sys_rst is released.
- MAX_RETRIES, 3: consecutive lock timeouts tolerated before entering FAIL (min 1).

Ports:
- clk  in  1  buffered 100 MHz system clock (clk_100_i domain).
- rst  in  1  synchronous, active-high reset.
- locked_async  in  1  MMCM LOCKED; asynchronous to clk.
- restart  in  1  single-cycle or level request to restart the full sequence (e.g. debounced button).
- mmcm_rst  out  1  MMCM RST.
- clk_ce  out  1  CE of the BUFGCE on the generated clock.
- phy_rst_n  out  1  active-low external PHY reset.
- sys_rst  out  1  active-high reset for logic on the generated clock; consumers resynchronise it.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- state  out  3  current state encoding, for ILA/LEDs.
- relock_count  out  8  count of lock losses after STABLE was reached; saturates at 255.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - mmcm_rst=1, clk_ce=0, phy_rst_n=0, sys_rst=1, ready=0, fail=0;
  - state=MMCM_RST, relock_count=0, retry counter=0, cycle counter=0, synchroniser flops=0.
- Registered outputs: all outputs are registered and decoded from the next state, so they change on the same edge as state.
- Synchronisation: locked_async passes through a 2-flop synchroniser to give locked_s. FSM sees an edge 2 cycles after it arrives.
- Cycle counter: one shared counter, width $clog2 of the largest timing parameter plus 1. Cleared on every state entry.
- State encodings: MMCM_RST=0, WAIT_LOCK=1, STABLE=2, PHY_RST=3, PHY_WAIT=4, RUN=5, FAIL=6.
- MMCM_RST:
  - mmcm_rst=1, all else at reset values.
  - After RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - mmcm_rst=0.
  - locked_s=1 goes to STABLE.
  - Otherwise, on the LOCK_TIMEOUT-th cycle, retry counter +1. If it now equals MAX_RETRIES, go to FAIL; else go to MMCM_RST.
- STABLE:
  - locked_s=0 returns to WAIT_LOCK with a fresh timeout; retry counter is unchanged.
  - After STABLE_CYCLES consecutive cycles, go to PHY_RST.
- PHY_RST:
  - clk_ce=1, phy_rst_n=0.
  - After PHY_RST_CYCLES, go to PHY_WAIT.
- PHY_WAIT:
  - clk_ce=1, phy_rst_n=1, sys_rst=1.
  - After PHY_WAIT_CYCLES, go to RUN.
- RUN:
  - clk_ce=1, phy_rst_n=1, sys_rst=0, ready=1.
  - Retry counter is cleared on entry.
- Lock loss: locked_s=0 in PHY_RST, PHY_WAIT or RUN triggers, on the next edge:
  - state=MMCM_RST, clk_ce=0, phy_rst_n=0, sys_rst=1, ready=0;
  - relock_count +1, saturating at 255.
- FAIL:
  - mmcm_rst=1 (MMCM held in reset), fail=1, all else at reset values.
  - Exits only via restart or rst.
- Priority: rst > restart > lock loss > timer/lock transitions.
  - restart in any state, FAIL included, goes to MMCM_RST and clears the retry and cycle counters. relock_count is preserved.
  - restart held high keeps the FSM in MMCM_RST.
- Glitches: a locked_async glitch of 1 cycle or more that reaches locked_s is a real loss. No filtering beyond the synchroniser.
- Ordering invariants:
  - clk_ce never 1 while mmcm_rst=1;
  - phy_rst_n never 1 while clk_ce=0;
  - sys_rst never 0 while phy_rst_n=0.

Decomposition:
- Package clk_seq_pkg holds:
  - state localparams and their 3-bit width;
  - a counter-width function (clog2 helper).
- Sub-module sync_2ff: generic 1-bit, 2-flop synchroniser with ASYNC_REG attributes. Reused by other blocks.
- Sequencer FSM and counters live in clk_rst_sequencer itself.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, PHY_RST_CYCLES=10, PHY_WAIT_CYCLES=5, MAX_RETRIES=2.
- Nominal bring-up: rst low; locked_async rises 3 cycles after mmcm_rst falls.
  - mmcm_rst high exactly 4 cycles.
  - state=STABLE 2 cycles after the rise.
  - clk_ce rises 8 cycles after entering STABLE.
  - phy_rst_n rises 10 cycles later.
  - sys_rst falls and ready rises 5 cycles after that; state=5.
- Lock timeout/retry: locked_async held 0.
  - Two 20-cycle WAIT_LOCK windows, each preceded by a 4-cycle mmcm_rst pulse.
  - Then state=6, fail=1, mmcm_rst=1, held indefinitely.
  - A restart pulse reruns the sequence.
- Lock loss in RUN: drop locked_async for 1 cycle.
  - 2 cycles later, clk_ce=0, phy_rst_n=0, sys_rst=1, ready=0, state=0.
  - relock_count increments 0 to 1.
  - With lock restored, full sequence repeats to RUN.
- Unstable lock: locked_async toggles with a 5-cycle period during STABLE.
  - FSM alternates WAIT_LOCK/STABLE; clk_ce never rises; retry counter is not incremented.
- Restart priority: assert restart in PHY_WAIT on the same cycle locked_async falls.
  - Next state=MMCM_RST; relock_count unchanged.
  - Restart overrides lock loss; no increment.
- Saturation: 260 forced lock losses from RUN → relock_count stops at 255.

Source files
------------

// File: rtl/clk_seq_pkg.sv
// Shared definitions for the clock/reset sequencer: state encoding and
// counter sizing helper.
package clk_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_MMCM_RST  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_PHY_RST   = 3'd3,
    ST_PHY_WAIT  = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAIL      = 3'd6
  } seq_state_e;

  // ceil(log2(max_val)) + 1, so a counter of this width can hold max_val itself
  function automatic int cnt_width(input int unsigned max_val);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(max_val)) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser for asynchronous level inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta_r;
  (* ASYNC_REG = "TRUE" *) logic sync_r;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/clk_rst_sequencer.sv
// Power-up / recovery sequencer for the Ethernet reference-clock MMCM:
// MMCM reset pulse, lock qualification, BUFGCE enable, PHY reset, system reset.
module clk_rst_sequencer
  import clk_seq_pkg::*;
#(
  parameter int RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT    = 100000,
  parameter int STABLE_CYCLES   = 1024,
  parameter int PHY_RST_CYCLES  = 1000000,
  parameter int PHY_WAIT_CYCLES = 5000,
  parameter int MAX_RETRIES     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               locked_async,
  input  logic               restart,
  output logic               mmcm_rst,
  output logic               clk_ce,
  output logic               phy_rst_n,
  output logic               sys_rst,
  output logic               ready,
  output logic               fail,
  output logic [STATE_W-1:0] state,
  output logic [7:0]         relock_count
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD  = (STABLE_CYCLES > PHY_RST_CYCLES) ? STABLE_CYCLES : PHY_RST_CYCLES;
  localparam int MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_T   = (MAX_ABC > PHY_WAIT_CYCLES) ? MAX_ABC : PHY_WAIT_CYCLES;
  localparam int CNT_W   = cnt_width(MAX_T);
  localparam int RETRY_W = cnt_width(MAX_RETRIES);

  localparam logic [CNT_W-1:0]   RST_LAST      = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   PHY_RST_LAST  = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   PHY_WAIT_LAST = CNT_W'(PHY_WAIT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX     = RETRY_W'(MAX_RETRIES);

  seq_state_e         state_r, state_next_s;
  logic [CNT_W-1:0]   cnt_r, cnt_next_s;
  logic [RETRY_W-1:0] retry_r, retry_next_s, retry_inc_s;
  logic [7:0]         relock_r, relock_next_s;
  logic               locked_s, lock_loss_s;
  logic               mmcm_rst_r, clk_ce_r, phy_rst_n_r, sys_rst_r, ready_r, fail_r;
  logic               mmcm_rst_next_s, clk_ce_next_s, phy_rst_n_next_s;
  logic               sys_rst_next_s, ready_next_s, fail_next_s;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (locked_async),
    .q   (locked_s)
  );

  // Only losses after the generated clock has been handed to consumers count.
  assign lock_loss_s = !locked_s && (state_r inside {ST_PHY_RST, ST_PHY_WAIT, ST_RUN});
  assign retry_inc_s = retry_r + RETRY_W'(1);

  // Next-state, retry and relock bookkeeping; restart outranks lock loss.
  always_comb begin
    state_next_s  = state_r;
    retry_next_s  = retry_r;
    relock_next_s = relock_r;
    if (restart) begin
      state_next_s = ST_MMCM_RST;
      retry_next_s = '0;
    end else if (lock_loss_s) begin
      state_next_s = ST_MMCM_RST;
      if (relock_r != 8'd255) relock_next_s = relock_r + 8'd1;
      else                    relock_next_s = relock_r;
    end else begin
      case (state_r)
        ST_MMCM_RST: begin
          if (cnt_r == RST_LAST) state_next_s = ST_WAIT_LOCK;
          else                   state_next_s = ST_MMCM_RST;
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_next_s = ST_STABLE;
          end else if (cnt_r == LOCK_LAST) begin
            retry_next_s = retry_inc_s;
            if (retry_inc_s == RETRY_MAX) state_next_s = ST_FAIL;
            else                          state_next_s = ST_MMCM_RST;
          end else begin
            state_next_s = ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          if (!locked_s)                 state_next_s = ST_WAIT_LOCK;
          else if (cnt_r == STABLE_LAST) state_next_s = ST_PHY_RST;
          else                           state_next_s = ST_STABLE;
        end
        ST_PHY_RST: begin
          if (cnt_r == PHY_RST_LAST) state_next_s = ST_PHY_WAIT;
          else                       state_next_s = ST_PHY_RST;
        end
        ST_PHY_WAIT: begin
          if (cnt_r == PHY_WAIT_LAST) begin
            state_next_s = ST_RUN;
            retry_next_s = '0;
          end else begin
            state_next_s = ST_PHY_WAIT;
          end
        end
        ST_RUN:  state_next_s = ST_RUN;
        ST_FAIL: state_next_s = ST_FAIL;
        default: state_next_s = ST_MMCM_RST;
      endcase
    end
  end

  // Shared cycle counter: zero on every state entry, parked in RUN and FAIL.
  always_comb begin
    cnt_next_s = cnt_r;
    if (restart || (state_next_s != state_r)) cnt_next_s = '0;
    else if (state_r == ST_RUN || state_r == ST_FAIL) cnt_next_s = cnt_r;
    else cnt_next_s = cnt_r + CNT_W'(1);
  end

  // Output decode from the next state so outputs move on the same edge as state.
  always_comb begin
    mmcm_rst_next_s  = 1'b1;
    clk_ce_next_s    = 1'b0;
    phy_rst_n_next_s = 1'b0;
    sys_rst_next_s   = 1'b1;
    ready_next_s     = 1'b0;
    fail_next_s      = 1'b0;
    case (state_next_s)
      ST_MMCM_RST:  mmcm_rst_next_s = 1'b1;
      ST_WAIT_LOCK: mmcm_rst_next_s = 1'b0;
      ST_STABLE:    mmcm_rst_next_s = 1'b0;
      ST_PHY_RST: begin
        mmcm_rst_next_s = 1'b0;
        clk_ce_next_s   = 1'b1;
      end
      ST_PHY_WAIT: begin
        mmcm_rst_next_s  = 1'b0;
        clk_ce_next_s    = 1'b1;
        phy_rst_n_next_s = 1'b1;
      end
      ST_RUN: begin
        mmcm_rst_next_s  = 1'b0;
        clk_ce_next_s    = 1'b1;
        phy_rst_n_next_s = 1'b1;
        sys_rst_next_s   = 1'b0;
        ready_next_s     = 1'b1;
      end
      ST_FAIL: fail_next_s = 1'b1;
      default: mmcm_rst_next_s = 1'b1;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_MMCM_RST;
      cnt_r       <= '0;
      retry_r     <= '0;
      relock_r    <= 8'd0;
      mmcm_rst_r  <= 1'b1;
      clk_ce_r    <= 1'b0;
      phy_rst_n_r <= 1'b0;
      sys_rst_r   <= 1'b1;
      ready_r     <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      retry_r     <= retry_next_s;
      relock_r    <= relock_next_s;
      mmcm_rst_r  <= mmcm_rst_next_s;
      clk_ce_r    <= clk_ce_next_s;
      phy_rst_n_r <= phy_rst_n_next_s;
      sys_rst_r   <= sys_rst_next_s;
      ready_r     <= ready_next_s;
      fail_r      <= fail_next_s;
    end
  end

  assign mmcm_rst     = mmcm_rst_r;
  assign clk_ce       = clk_ce_r;
  assign phy_rst_n    = phy_rst_n_r;
  assign sys_rst      = sys_rst_r;
  assign ready        = ready_r;
  assign fail         = fail_r;
  assign state        = state_r;
  assign relock_count = relock_r;

endmodule
